dma_frame_packer: RTL and testbench



---
 rtl/dma_frame_packer.sv | 167 ++++++++++++++++
 tb/tb_dma_frame_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_frame_packer.sv
// Frames the router's unframed 128-bit AXI-Stream for an AXI DMA S2MM channel:
// inserts tlast at programmed byte boundaries, masks tkeep on the partial tail beat.
module dma_frame_packer #(
    parameter int DWIDTH = 128,
    parameter int KWIDTH = DWIDTH / 8,
    parameter int LEN_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_frame_bytes,
    input  logic [CNT_W-1:0]  cfg_frame_cnt,
    input  logic              cfg_abort,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [KWIDTH-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  frames_done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ABORT} state_t;

    state_t state, state_next;

    logic [LEN_W-1:0]  last_idx_r, beat_idx;
    logic [CNT_W-1:0]  last_frame_r, frame_tag;
    logic [KWIDTH-1:0] keep_last_r;

    // two-entry skid buffer; the head entry drives the master port directly
    logic [1:0][DWIDTH-1:0] buf_data;
    logic [1:0][KWIDTH-1:0] buf_keep;
    logic [1:0]             buf_last;
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             used, used_next;

    logic [LEN_W-1:0]  rem_calc, beats_calc;
    logic [KWIDTH-1:0] keep_calc;
    logic              cfg_bad, start_ok, done_next, err_set;
    logic              in_hs, out_hs, beat_last, frame_last;

    assign rem_calc   = cfg_frame_bytes % LEN_W'(KWIDTH);
    assign beats_calc = cfg_frame_bytes / LEN_W'(KWIDTH) + LEN_W'(rem_calc != '0);
    assign cfg_bad    = (cfg_frame_bytes == '0) || (cfg_frame_cnt == '0);

    for (genvar i = 0; i < KWIDTH; i++) begin : g_keep
        assign keep_calc[i] = (rem_calc == '0) || (rem_calc > LEN_W'(i));
    end

    assign in_hs      = s_axis_tvalid && s_axis_tready;
    assign out_hs     = m_axis_tvalid && m_axis_tready;
    assign beat_last  = (beat_idx == last_idx_r);
    assign frame_last = (frame_tag == last_frame_r);
    assign used_next  = used + 2'(in_hs) - 2'(out_hs);

    assign busy          = (state != IDLE);
    assign m_axis_tvalid = (used != 2'd0);
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tkeep  = buf_keep[rd_ptr];
    // on abort the last beat still buffered closes the truncated frame
    assign m_axis_tlast  = buf_last[rd_ptr] || ((state == ABORT) && (used == 2'd1));

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        done_next  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_bad) begin
                        err_set   = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (cfg_abort)
                    state_next = ABORT;
                else if (in_hs && beat_last && frame_last)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (used == 2'd0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            ABORT: begin
                if (used == 2'd0) begin
                    done_next  = 1'b1;
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            frames_done   <= '0;
            last_idx_r    <= '0;
            last_frame_r  <= '0;
            keep_last_r   <= '0;
            beat_idx      <= '0;
            frame_tag     <= '0;
            buf_data      <= '0;
            buf_keep      <= '0;
            buf_last      <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            used          <= 2'd0;
        end else begin
            state         <= state_next;
            done          <= done_next;
            s_axis_tready <= (state_next == RUN) && (used_next != 2'd2);
            used          <= used_next;

            if (start_ok) begin
                last_idx_r   <= beats_calc - LEN_W'(1);
                last_frame_r <= cfg_frame_cnt - CNT_W'(1);
                keep_last_r  <= keep_calc;
                beat_idx     <= '0;
                frame_tag    <= '0;
                err          <= 1'b0;
                frames_done  <= '0;
            end else begin
                if (err_set)
                    err <= 1'b1;
                if (out_hs && buf_last[rd_ptr] && (frames_done != '1))
                    frames_done <= frames_done + CNT_W'(1);
            end

            if (in_hs) begin
                buf_data[wr_ptr] <= s_axis_tdata;
                buf_keep[wr_ptr] <= beat_last ? keep_last_r : '1;
                buf_last[wr_ptr] <= beat_last;
                wr_ptr           <= ~wr_ptr;
                if (beat_last) begin
                    beat_idx  <= '0;
                    frame_tag <= frame_tag + CNT_W'(1);
                end else begin
                    beat_idx <= beat_idx + LEN_W'(1);
                end
            end

            if (out_hs)
                rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: tb/tb_dma_frame_packer.sv
// Directed bench for dma_frame_packer: vector table of framing jobs plus
// hand-written bad-config and mid-job reset sequences.
module tb_dma_frame_packer;

    localparam int DW = 128;
    localparam int KW = 16;
    localparam int LW = 24;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_start, cfg_abort;
    logic [LW-1:0] cfg_frame_bytes;
    logic [CW-1:0] cfg_frame_cnt;
    logic [DW-1:0] s_axis_tdata, m_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [KW-1:0] m_axis_tkeep;
    logic          busy, done, err;
    logic [CW-1:0] frames_done;

    always #5 clk = ~clk;

    dma_frame_packer #(.DWIDTH(DW), .KWIDTH(KW), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_frame_bytes(cfg_frame_bytes),
        .cfg_frame_cnt(cfg_frame_cnt), .cfg_abort(cfg_abort),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .err(err), .frames_done(frames_done)
    );

    // bpf = hand-computed beats per frame, keep_last = hand-computed tail tkeep
    typedef struct {
        int          bytes;
        int          cnt;
        int          n_in;
        int          rdy50;
        int          abort_at;
        int          sa;
        int          exp_out;
        int          bpf;
        logic [15:0] keep_last;
        int          exp_frames;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int j, input int k);
        return {32'(j), 32'hC0DE_0000, 32'(k), ~32'(k)};
    endfunction

    task automatic run_job(input vec_t v, input int j);
        int          sent, got, occ, max_occ, cyc;
        bit          done_seen, stall, chk_rdy, ab_done, exp_last;
        logic [127:0] pd;
        logic [15:0] pk;
        logic        pl, in_hs, out_hs;
        sent = 0; got = 0; occ = 0; max_occ = 0; cyc = 0;
        done_seen = 0; stall = 0; chk_rdy = 0; ab_done = 0;
        pd = '0; pk = '0; pl = 1'b0;

        @(negedge clk);
        cfg_frame_bytes = LW'(v.bytes);
        cfg_frame_cnt   = CW'(v.cnt);
        cfg_start       = 1'b1;
        cfg_abort       = 1'(v.sa);
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("err_cleared_on_start", 128'(err), 128'(0));
        chk("frames_done_cleared", 128'(frames_done), 128'(0));

        while (!done_seen) begin
            if (cyc == 500) begin
                n_vec++; n_bad++;
                $display("FAIL job_timeout: job %0d got %0d beats, no done", j, got);
                done_seen = 1;
            end else begin
                if (stall) begin
                    chk("stall_valid_held", 128'(m_axis_tvalid), 128'(1));
                    chk("stall_data_stable", m_axis_tdata, pd);
                    chk("stall_keep_stable", 128'(m_axis_tkeep), 128'(pk));
                    chk("stall_last_stable", 128'(m_axis_tlast), 128'(pl));
                end
                if (chk_rdy) begin
                    chk("tready_drop", 128'(s_axis_tready), 128'(0));
                    chk_rdy = 0;
                end
                if (done) begin
                    done_seen = 1;
                end else begin
                    m_axis_tready = (v.rdy50 != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                    s_axis_tvalid = (sent < v.n_in);
                    s_axis_tdata  = pat(j, sent);
                    cfg_abort     = (v.abort_at > 0) && (sent == v.abort_at - 1) && !ab_done;
                    if (cfg_abort) ab_done = 1;
                    in_hs  = s_axis_tvalid && s_axis_tready;
                    out_hs = m_axis_tvalid && m_axis_tready;
                    if (out_hs) begin
                        exp_last = ((got + 1) % v.bpf == 0) ||
                                   ((v.abort_at > 0) && (got == v.exp_out - 1));
                        chk("out_data", m_axis_tdata, pat(j, got));
                        chk("out_keep", 128'(m_axis_tkeep),
                            128'(((got + 1) % v.bpf == 0) ? v.keep_last : 16'hFFFF));
                        chk("out_last", 128'(m_axis_tlast), 128'(exp_last));
                        got++;
                    end
                    stall = m_axis_tvalid && !m_axis_tready;
                    pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
                    if (in_hs) begin
                        sent++;
                        if (sent == v.n_in) chk_rdy = 1;
                    end
                    occ = occ + int'(in_hs) - int'(out_hs);
                    if (occ > max_occ) max_occ = occ;
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        cfg_abort     = 1'b0;

        chk("out_count", 128'(got), 128'(v.exp_out));
        chk("in_count", 128'(sent), 128'(v.n_in));
        chk("frames_done", 128'(frames_done), 128'(v.exp_frames));
        chk("err_end", 128'(err), 128'(v.exp_err));
        chk("busy_end", 128'(busy), 128'(0));
        chk("occupancy_le_2", 128'(max_occ <= 2), 128'(1));
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, 128'(m_axis_tvalid), 128'(0));
        chk({tag, "_m_tdata"}, m_axis_tdata, 128'(0));
        chk({tag, "_m_tkeep"}, 128'(m_axis_tkeep), 128'(0));
        chk({tag, "_m_tlast"}, 128'(m_axis_tlast), 128'(0));
        chk({tag, "_s_tready"}, 128'(s_axis_tready), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
        chk({tag, "_frames_done"}, 128'(frames_done), 128'(0));
    endtask

    initial begin
        //            bytes cnt n_in r50 ab sa out bpf keep      frm err
        vecs[0] = '{   64,  2,   8,  0, 0, 0,  8,  4, 16'hFFFF, 2, 0};
        vecs[1] = '{   40,  1,   3,  0, 0, 0,  3,  3, 16'h00FF, 1, 0};
        vecs[2] = '{  160,  1,  10,  1, 0, 0, 10, 10, 16'hFFFF, 1, 0};
        vecs[3] = '{  256,  1,   5,  0, 5, 0,  5, 16, 16'hFFFF, 0, 1};
        vecs[4] = '{   17,  3,   6,  1, 0, 1,  6,  2, 16'h0001, 3, 0};
        vecs[5] = '{    1,  2,   2,  0, 0, 0,  2,  1, 16'h0001, 2, 0};

        rst = 1'b1;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_frame_bytes = '0; cfg_frame_cnt = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // rejected configs: zero bytes, then zero frame count
        @(negedge clk);
        cfg_frame_bytes = '0; cfg_frame_cnt = CW'(1); cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("bad_bytes_err", 128'(err), 128'(1));
        chk("bad_bytes_done", 128'(done), 128'(1));
        chk("bad_bytes_busy", 128'(busy), 128'(0));
        @(negedge clk);
        chk("bad_bytes_done_clr", 128'(done), 128'(0));
        chk("bad_bytes_busy2", 128'(busy), 128'(0));
        cfg_frame_bytes = LW'(5); cfg_frame_cnt = '0; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("bad_cnt_err", 128'(err), 128'(1));
        chk("bad_cnt_done", 128'(done), 128'(1));
        chk("bad_cnt_busy", 128'(busy), 128'(0));

        // abort in IDLE must be ignored
        @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("idle_abort_busy", 128'(busy), 128'(0));
        chk("idle_abort_done", 128'(done), 128'(0));

        for (int i = 0; i < 6; i++) run_job(vecs[i], i + 1);

        // asynchronous reset in the middle of a job, after 3 input beats
        @(negedge clk);
        cfg_frame_bytes = LW'(64); cfg_frame_cnt = CW'(1); cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_axis_tdata = pat(9, k);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        chk("pre_reset_valid", 128'(m_axis_tvalid), 128'(1));
        #2 rst = 1'b1;
        #1 check_reset_outputs("midjob_reset");
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t r;
            r = '{64, 1, 4, 0, 0, 0, 4, 4, 16'hFFFF, 1, 0};
            run_job(r, 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
